// File: rtl/mem_bus_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the memory controller app_* port.
// The arbiter takes the slave view; the requesters and controller model take the master view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  localparam int MASK_W = DATA_W / 8;

  logic              core_bus_en;

  logic              p0_valid;
  logic              p0_ready;
  logic              p0_cmd;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [MASK_W-1:0] p0_wmask;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_rvalid;
  logic              p0_rerr;

  logic              p1_valid;
  logic              p1_ready;
  logic              p1_cmd;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic [MASK_W-1:0] p1_wmask;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_rvalid;
  logic              p1_rerr;

  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_end;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_rdy;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;

  modport slave (
    input  core_bus_en,
    input  p0_valid, p0_cmd, p0_addr, p0_wdata, p0_wmask,
    output p0_ready, p0_rdata, p0_rvalid, p0_rerr,
    input  p1_valid, p1_cmd, p1_addr, p1_wdata, p1_wmask,
    output p1_ready, p1_rdata, p1_rvalid, p1_rerr,
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_mask, app_wdf_wren,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport master (
    output core_bus_en,
    output p0_valid, p0_cmd, p0_addr, p0_wdata, p0_wmask,
    input  p0_ready, p0_rdata, p0_rvalid, p0_rerr,
    output p1_valid, p1_cmd, p1_addr, p1_wdata, p1_wmask,
    input  p1_ready, p1_rdata, p1_rvalid, p1_rerr,
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_mask, app_wdf_wren,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter in front of the DDR app_* interface: one transaction
// in flight, read beats routed to the issuing port, read-return watchdog.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 1023
) (
  input logic             clk,
  input logic             resetn,
  mem_bus_arbiter_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic              r_last_grant;
  logic              r_grant;
  logic              r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic              r_cmd_done;
  logic              r_data_done;
  logic [WD_W-1:0]   r_wdog;

  logic [1:0] w_elig;
  logic       w_any_elig;
  logic       w_pick;
  logic       w_cmd_acc;
  logic       w_data_acc;
  logic       w_cmd_done_next;
  logic       w_data_done_next;
  logic       w_beat;
  logic       w_beat_last;
  logic       w_wdog_expire;
  logic       w_timeout;

  // Port 1 is only eligible while sys_ctrl has handed the bus to the core.
  assign w_elig     = {bus.p1_valid & bus.core_bus_en, bus.p0_valid};
  assign w_any_elig = |w_elig;
  assign w_pick     = (&w_elig) ? ~r_last_grant : w_elig[1];

  assign w_cmd_acc        = (r_state == ST_ISSUE) && !r_cmd_done && bus.app_rdy;
  assign w_data_acc       = (r_state == ST_ISSUE) && !r_cmd && !r_data_done && bus.app_wdf_rdy;
  assign w_cmd_done_next  = r_cmd_done | w_cmd_acc;
  assign w_data_done_next = r_data_done | w_data_acc;

  // Beats arriving outside RDWAIT belong to nobody and are dropped here.
  assign w_beat        = (r_state == ST_RDWAIT) && bus.app_rd_data_valid;
  assign w_beat_last   = w_beat && bus.app_rd_data_end;
  assign w_wdog_expire = (TIMEOUT != 0) && (r_wdog == WD_W'(TIMEOUT - 1));
  assign w_timeout     = (r_state == ST_RDWAIT) && w_wdog_expire && !w_beat_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_elig) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_cmd) begin
          if (w_cmd_acc) begin
            w_state_next = ST_RDWAIT;
          end
        end else if (w_cmd_done_next && w_data_done_next) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RDWAIT: begin
        if (w_beat_last || w_timeout) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_cmd        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_cmd_done   <= 1'b0;
      r_data_done  <= 1'b0;
      r_wdog       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_elig) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_cmd        <= w_pick ? bus.p1_cmd   : bus.p0_cmd;
            r_addr       <= w_pick ? bus.p1_addr  : bus.p0_addr;
            r_wdata      <= w_pick ? bus.p1_wdata : bus.p0_wdata;
            r_wmask      <= w_pick ? bus.p1_wmask : bus.p0_wmask;
            r_cmd_done   <= 1'b0;
            r_data_done  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          r_cmd_done  <= w_cmd_done_next;
          r_data_done <= w_data_done_next;
          r_wdog      <= '0;
        end
        ST_RDWAIT: begin
          r_wdog <= r_wdog + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Command and write-data channels handshake independently; each drops once seen.
  assign bus.app_en       = (r_state == ST_ISSUE) && !r_cmd_done;
  assign bus.app_wdf_wren = (r_state == ST_ISSUE) && !r_cmd && !r_data_done;
  assign bus.app_wdf_end  = bus.app_wdf_wren;
  assign bus.app_cmd      = {2'b00, r_cmd};
  assign bus.app_addr     = r_addr;
  assign bus.app_wdf_data = r_wdata;
  assign bus.app_wdf_mask = r_wmask;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic              r_ready;
    logic              r_rvalid;
    logic              r_rerr;
    logic [DATA_W-1:0] r_rdata;
    logic              w_sel;

    assign w_sel = (r_grant == 1'(gi));

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_ready  <= 1'b0;
        r_rvalid <= 1'b0;
        r_rerr   <= 1'b0;
        r_rdata  <= '0;
      end else begin
        r_ready  <= (r_state == ST_IDLE) && w_any_elig && (w_pick == 1'(gi));
        r_rvalid <= w_beat && w_sel;
        r_rerr   <= w_timeout && w_sel;
        if (w_beat && w_sel) begin
          r_rdata <= bus.app_rd_data;
        end
      end
    end
  end

  assign bus.p0_ready  = g_port[0].r_ready;
  assign bus.p0_rvalid = g_port[0].r_rvalid;
  assign bus.p0_rerr   = g_port[0].r_rerr;
  assign bus.p0_rdata  = g_port[0].r_rdata;
  assign bus.p1_ready  = g_port[1].r_ready;
  assign bus.p1_rvalid = g_port[1].r_rvalid;
  assign bus.p1_rerr   = g_port[1].r_rerr;
  assign bus.p1_rdata  = g_port[1].r_rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: grants, read beats and timeouts are predicted
// into queues as stimulus is driven and checked by a negedge monitor.
module tb_mem_bus_arbiter;
  localparam int ADDR_W  = 28;
  localparam int DATA_W  = 128;
  localparam int TIMEOUT = 16;

  typedef struct {
    int                port;
    logic [DATA_W-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad = 0;
  int n_cmd_acc = 0;
  int n_wr_acc = 0;
  int tb_last = 1;
  int exp_grant[$];
  rd_t exp_rd[$];
  int exp_err[$];

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int p);
    return (p == 0) ? 2'b01 : (p == 1) ? 2'b10 : 2'b00;
  endfunction

  // Monitor: every ready/rvalid/rerr pulse must match the next predicted event.
  int  mon_e;
  rd_t mon_rd;
  always @(negedge clk) begin
    if (bus.app_en && bus.app_rdy) n_cmd_acc++;
    if (bus.app_wdf_wren && bus.app_wdf_rdy) n_wr_acc++;
    if (bus.p0_ready || bus.p1_ready) begin
      mon_e = (exp_grant.size() > 0) ? exp_grant.pop_front() : -1;
      check("grant", {bus.p1_ready, bus.p0_ready}, onehot(mon_e));
    end
    if (bus.p0_rvalid || bus.p1_rvalid) begin
      if (exp_rd.size() > 0) begin
        mon_rd = exp_rd.pop_front();
      end else begin
        mon_rd.port = -1;
        mon_rd.data = '0;
      end
      check("rvalid_port", {bus.p1_rvalid, bus.p0_rvalid}, onehot(mon_rd.port));
      check("rdata", bus.p1_rvalid ? bus.p1_rdata : bus.p0_rdata, mon_rd.data);
    end
    if (bus.p0_rerr || bus.p1_rerr) begin
      mon_e = (exp_err.size() > 0) ? exp_err.pop_front() : -1;
      check("rerr_port", {bus.p1_rerr, bus.p0_rerr}, onehot(mon_e));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int port);
    int k;
    for (k = 0; k < 50; k++) begin
      cyc();
      if ((port == 0 && bus.p0_ready) || (port == 1 && bus.p1_ready)) break;
    end
    check("ready_seen", 1'(k < 50), 1'b1);
  endtask

  task automatic req(input int port, input logic cmd, input logic [ADDR_W-1:0] addr,
                     input logic [DATA_W-1:0] wdata, input logic [15:0] wmask);
    if (port == 0) begin
      bus.p0_cmd = cmd; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_wmask = wmask;
      bus.p0_valid = 1'b1;
    end else begin
      bus.p1_cmd = cmd; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_wmask = wmask;
      bus.p1_valid = 1'b1;
    end
    exp_grant.push_back(port);
    tb_last = port;
    wait_ready(port);
    bus.p0_valid = 1'b0;
    bus.p1_valid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_flags"}, {bus.p0_ready, bus.p1_ready, bus.p0_rvalid, bus.p1_rvalid,
                            bus.p0_rerr, bus.p1_rerr, bus.app_en, bus.app_wdf_wren,
                            bus.app_wdf_end, bus.app_cmd}, '0);
    check({tag, "_addr"}, bus.app_addr, '0);
    check({tag, "_rdata"}, bus.p0_rdata | bus.p1_rdata, '0);
  endtask

  int c_cmd, c_wr, n, k, cnt;
  logic [DATA_W-1:0] d1, d2;

  initial begin
    bus.core_bus_en = 1'b0;
    bus.p0_valid = 1'b0; bus.p0_cmd = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_wmask = '0;
    bus.p1_valid = 1'b0; bus.p1_cmd = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_wmask = '0;
    bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0; bus.app_rd_data = '0;
    bus.app_rd_data_valid = 1'b0; bus.app_rd_data_end = 1'b0;
    d1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    d2 = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;

    cyc(); cyc();
    check_quiet("reset");
    resetn = 1'b1;
    cyc();

    // Single p0 write with both ready lines high.
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    c_cmd = n_cmd_acc; c_wr = n_wr_acc;
    req(0, 1'b0, 28'h10, 128'hAA << 8, 16'h0002);
    @(negedge clk);
    check("w1_app_en", bus.app_en, 1'b1);
    check("w1_wren", bus.app_wdf_wren, 1'b1);
    check("w1_wdf_end", bus.app_wdf_end, 1'b1);
    check("w1_mask", bus.app_wdf_mask, 16'h0002);
    check("w1_addr", bus.app_addr, 28'h10);
    check("w1_cmd", bus.app_cmd, 3'b000);
    check("w1_wdata", bus.app_wdf_data, 128'hAA00);
    cyc();
    check("w1_en_drop", {bus.app_en, bus.app_wdf_wren}, 2'b00);
    check("w1_cmd_acc", n_cmd_acc - c_cmd, 1);
    check("w1_wr_acc", n_wr_acc - c_wr, 1);

    // Both ports requesting continuously: grants must alternate.
    bus.core_bus_en = 1'b1;
    bus.p0_cmd = 1'b0; bus.p0_addr = 28'h100; bus.p0_wmask = 16'hFFFF;
    bus.p1_cmd = 1'b0; bus.p1_addr = 28'h200; bus.p1_wmask = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      exp_grant.push_back(1 - tb_last);
      tb_last = 1 - tb_last;
    end
    bus.p0_valid = 1'b1; bus.p1_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 100 && n < 6; c++) begin
      cyc();
      if (bus.p0_ready || bus.p1_ready) n++;
    end
    bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
    check("alt_grants", n, 6);
    cyc(); cyc();

    // Port 1 locked out while core_bus_en is low.
    bus.core_bus_en = 1'b0;
    bus.p1_valid = 1'b1;
    cnt = 0;
    repeat (100) begin
      cyc();
      if (bus.p1_ready) cnt++;
    end
    check("p1_blocked", cnt, 0);
    bus.core_bus_en = 1'b1;
    exp_grant.push_back(1);
    tb_last = 1;
    wait_ready(1);
    bus.p1_valid = 1'b0;
    cyc(); cyc();

    // p1 read, command accept delayed 5 cycles, two beats returned.
    bus.app_rdy = 1'b0;
    c_cmd = n_cmd_acc;
    req(1, 1'b1, 28'h123, '0, '0);
    repeat (5) cyc();
    check("rd_app_en_held", bus.app_en, 1'b1);
    check("rd_app_cmd", bus.app_cmd, 3'b001);
    bus.app_rdy = 1'b1;
    cyc();
    bus.app_rdy = 1'b0;
    bus.app_rd_data_valid = 1'b1; bus.app_rd_data = d1; bus.app_rd_data_end = 1'b0;
    exp_rd.push_back('{port: 1, data: d1});
    cyc();
    bus.app_rd_data = d2; bus.app_rd_data_end = 1'b1;
    exp_rd.push_back('{port: 1, data: d2});
    cyc();
    bus.app_rd_data_valid = 1'b0; bus.app_rd_data_end = 1'b0;
    cyc(); cyc();
    check("rd_beats_left", exp_rd.size(), 0);
    check("rd_cmd_acc", n_cmd_acc - c_cmd, 1);
    check("rd_p1_rdata_hold", bus.p1_rdata, d2);

    // Stray beats in IDLE are dropped (monitor flags any rvalid).
    bus.app_rd_data_valid = 1'b1; bus.app_rd_data = 128'h5555; bus.app_rd_data_end = 1'b1;
    cyc(); cyc();
    bus.app_rd_data_valid = 1'b0; bus.app_rd_data_end = 1'b0;
    cyc();
    check("stray_p1_rdata", bus.p1_rdata, d2);

    // Write data accepted before command, then the reverse order.
    bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b1;
    c_cmd = n_cmd_acc; c_wr = n_wr_acc;
    req(0, 1'b0, 28'h30, 128'h77, 16'h00F0);
    repeat (3) cyc();
    bus.app_rdy = 1'b1;
    repeat (3) cyc();
    check("wd_first_cmd_acc", n_cmd_acc - c_cmd, 1);
    check("wd_first_wr_acc", n_wr_acc - c_wr, 1);
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b0;
    c_cmd = n_cmd_acc; c_wr = n_wr_acc;
    req(0, 1'b0, 28'h34, 128'h88, 16'h0F00);
    repeat (3) cyc();
    check("cmd_first_wren_held", bus.app_wdf_wren, 1'b1);
    bus.app_wdf_rdy = 1'b1;
    repeat (3) cyc();
    check("cmd_first_cmd_acc", n_cmd_acc - c_cmd, 1);
    check("cmd_first_wr_acc", n_wr_acc - c_wr, 1);

    // Read with no return: rerr 16 cycles after command accept.
    req(0, 1'b1, 28'h40, '0, '0);
    cyc();
    exp_err.push_back(0);
    for (k = 1; k <= 40; k++) begin
      cyc();
      if (bus.p0_rerr) break;
    end
    check("rerr_latency", k, TIMEOUT);
    cyc();
    check("rerr_pulse_width", bus.p0_rerr, 1'b0);
    check("rerr_left", exp_err.size(), 0);

    // Reset in the middle of RDWAIT, then a late beat that must be ignored.
    req(1, 1'b1, 28'h50, '0, '0);
    repeat (4) cyc();
    resetn = 1'b0;
    #1;
    check_quiet("midreset");
    cyc(); cyc();
    resetn = 1'b1;
    tb_last = 1;
    bus.app_rd_data_valid = 1'b1; bus.app_rd_data = 128'h9999; bus.app_rd_data_end = 1'b1;
    cyc();
    bus.app_rd_data_valid = 1'b0; bus.app_rd_data_end = 1'b0;
    cyc();
    check("post_reset_rdata", bus.p1_rdata, '0);

    // Bus still usable after reset.
    c_cmd = n_cmd_acc; c_wr = n_wr_acc;
    req(0, 1'b0, 28'h60, 128'h42, 16'h0001);
    cyc(); cyc();
    check("post_reset_cmd_acc", n_cmd_acc - c_cmd, 1);
    check("post_reset_wr_acc", n_wr_acc - c_wr, 1);

    check("grants_left", exp_grant.size(), 0);
    check("beats_left", exp_rd.size(), 0);
    check("errs_left", exp_err.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
